// File: rtl/pipeline_4_writeback_if.sv
// rtl/pipeline_4_writeback_if.sv - writeback stage bus: capture, load return, read ports, status
interface pipeline_4_writeback_if #(
   parameter int DATA_W = 16
);
   logic              update;
   logic              valid_in;
   logic [2:0]        num_Rd_in;
   logic [DATA_W-1:0] result_in;
   logic              write_in;
   logic              loads_in;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic [2:0]        num_Rm;
   logic [2:0]        num_Rn;
   logic [2:0]        num_Rd;
   logic [DATA_W-1:0] data_Rm;
   logic [DATA_W-1:0] data_Rn;
   logic [DATA_W-1:0] data_Rd;
   logic              stall_out;
   logic [2:0]        pending_Rd;
   logic [15:0]       retire_count;

   modport master (
      output update, valid_in, num_Rd_in, result_in, write_in, loads_in,
      output mem_rvalid, mem_rdata, num_Rm, num_Rn, num_Rd,
      input  data_Rm, data_Rn, data_Rd, stall_out, pending_Rd, retire_count
   );

   modport slave (
      input  update, valid_in, num_Rd_in, result_in, write_in, loads_in,
      input  mem_rvalid, mem_rdata, num_Rm, num_Rn, num_Rd,
      output data_Rm, data_Rn, data_Rd, stall_out, pending_Rd, retire_count
   );
endinterface

// File: rtl/pipeline_4_writeback.sv
// rtl/pipeline_4_writeback.sv - writeback stage, 8x16 register file, load-wait stall FSM
// Optional read bypass of stage result and returning load data: define WB_BYPASS_EN.
module pipeline_4_writeback #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_4_writeback_if.slave wb
);

   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic              write_q, write_d;
   logic              loads_q, loads_d;
   logic [2:0]        rd_q, rd_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [2:0]        pend_q, pend_d;
   logic [15:0]       count_q, count_d;
   logic [DATA_W-1:0] rf_q [NREG];

   logic              capture;
   logic              we;
   logic [2:0]        waddr;
   logic [DATA_W-1:0] wdata;

   // Upstream is only accepted while no load is outstanding.
   assign capture = wb.update && (state_q == IDLE);

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      write_d  = write_q;
      loads_d  = loads_q;
      rd_d     = rd_q;
      result_d = result_q;
      pend_d   = pend_q;
      count_d  = count_q;
      we       = 1'b0;
      waddr    = rd_q;
      wdata    = result_q;

      case (state_q)
         IDLE: begin
            if (valid_q && write_q) begin
               if (loads_q) begin
                  state_d = LOAD_WAIT;
                  pend_d  = rd_q;
               end else begin
                  we = 1'b1;
               end
            end
            valid_d = 1'b0;
            if (capture) begin
               valid_d  = wb.valid_in;
               write_d  = wb.write_in;
               loads_d  = wb.loads_in;
               rd_d     = wb.num_Rd_in;
               result_d = wb.result_in;
            end
         end
         LOAD_WAIT: begin
            if (wb.mem_rvalid) begin
               we      = 1'b1;
               waddr   = pend_q;
               wdata   = wb.mem_rdata;
               state_d = IDLE;
               pend_d  = 3'd0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (we) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         valid_q  <= 1'b0;
         write_q  <= 1'b0;
         loads_q  <= 1'b0;
         rd_q     <= 3'd0;
         result_q <= '0;
         pend_q   <= 3'd0;
         count_q  <= 16'd0;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         write_q  <= write_d;
         loads_q  <= loads_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         pend_q   <= pend_d;
         count_q  <= count_d;
         if (we) begin
            rf_q[waddr] <= wdata;
         end
      end
   end

   logic [2:0]        raddr [3];
   logic [DATA_W-1:0] rdata [3];

   assign raddr[0] = wb.num_Rm;
   assign raddr[1] = wb.num_Rn;
   assign raddr[2] = wb.num_Rd;

`ifdef WB_BYPASS_EN
   logic alu_fwd;
   logic mem_fwd;
   assign alu_fwd = valid_q && write_q && !loads_q;
   assign mem_fwd = (state_q == LOAD_WAIT) && wb.mem_rvalid;
`endif

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rdata[p] = rf_q[raddr[p]];
`ifdef WB_BYPASS_EN
         // Stage result is younger than the outstanding load, so it wins.
         if (mem_fwd && (raddr[p] == pend_q)) begin
            rdata[p] = wb.mem_rdata;
         end
         if (alu_fwd && (raddr[p] == rd_q)) begin
            rdata[p] = result_q;
         end
`endif
      end
   end

   assign wb.data_Rm      = rdata[0];
   assign wb.data_Rn      = rdata[1];
   assign wb.data_Rd      = rdata[2];
   assign wb.stall_out    = (state_q == LOAD_WAIT);
   assign wb.pending_Rd   = pend_q;
   assign wb.retire_count = count_q;

endmodule

// File: tb/tb_pipeline_4_writeback.sv
// tb/tb_pipeline_4_writeback.sv - random and directed bench for pipeline_4_writeback
module tb_pipeline_4_writeback;

   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_4_writeback_if #(.DATA_W(DATA_W)) wb ();

   pipeline_4_writeback #(.DATA_W(DATA_W), .NREG(8)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   int checks = 0;
   int errors = 0;

   // Architectural model: register contents, the one in-flight instruction,
   // and the outstanding load (if any).
   logic [15:0] m_rf [8];
   logic [15:0] m_count;
   bit          m_wait;
   logic [2:0]  m_pend;
   bit          s_valid, s_write, s_loads;
   logic [2:0]  s_rd;
   logic [15:0] s_res;

   task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] a);
      logic [15:0] v;
      v = m_rf[a];
`ifdef WB_BYPASS_EN
      if (m_wait && wb.mem_rvalid && a == m_pend) v = wb.mem_rdata;
      if (s_valid && s_write && !s_loads && a == s_rd) v = s_res;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      m_count = 16'h0;
      m_wait  = 1'b0;
      m_pend  = 3'd0;
      s_valid = 1'b0;
      s_write = 1'b0;
      s_loads = 1'b0;
      s_rd    = 3'd0;
      s_res   = 16'h0;
   endtask

   task automatic model_edge();
      if (!rst) begin
         model_reset();
      end else if (m_wait) begin
         if (wb.mem_rvalid) begin
            m_rf[m_pend] = wb.mem_rdata;
            m_count      = m_count + 16'd1;
            m_wait       = 1'b0;
            m_pend       = 3'd0;
         end
      end else begin
         if (s_valid && s_write) begin
            if (s_loads) begin
               m_wait = 1'b1;
               m_pend = s_rd;
            end else begin
               m_rf[s_rd] = s_res;
               m_count    = m_count + 16'd1;
            end
         end
         s_valid = 1'b0;
         if (wb.update) begin
            s_valid = wb.valid_in;
            s_write = wb.write_in;
            s_loads = wb.loads_in;
            s_rd    = wb.num_Rd_in;
            s_res   = wb.result_in;
         end
      end
   endtask

   task automatic check_outputs();
      chk_eq("stall_out", {15'd0, wb.stall_out}, {15'd0, m_wait});
      chk_eq("pending_Rd", {13'd0, wb.pending_Rd}, {13'd0, m_pend});
      chk_eq("retire_count", wb.retire_count, m_count);
      chk_eq("data_Rm", wb.data_Rm, m_read(wb.num_Rm));
      chk_eq("data_Rn", wb.data_Rn, m_read(wb.num_Rn));
      chk_eq("data_Rd", wb.data_Rd, m_read(wb.num_Rd));
   endtask

   task automatic tick(input bit do_chk);
      #1;
      if (do_chk) check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input bit upd, input bit vld, input logic [2:0] rd, input logic [15:0] res,
                        input bit wr, input bit ld, input bit mrv, input logic [15:0] mrd);
      wb.update     = upd;
      wb.valid_in   = vld;
      wb.num_Rd_in  = rd;
      wb.result_in  = res;
      wb.write_in   = wr;
      wb.loads_in   = ld;
      wb.mem_rvalid = mrv;
      wb.mem_rdata  = mrd;
   endtask

   task automatic set_reads(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      wb.num_Rm = a;
      wb.num_Rn = b;
      wb.num_Rd = c;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_beef;
      int n;

      model_reset();
      rst = 1'b0;
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      set_reads(3'd0, 3'd0, 3'd0);
      @(negedge clk);
      tick(0);
      rst = 1'b1;

      // Reset state
      for (int i = 0; i < 8; i++) begin
         set_reads(i[2:0], i[2:0], i[2:0]);
         #1;
         chk_eq($sformatf("rst_R%0d", i), wb.data_Rm, 16'h0000);
      end
      chk_eq("rst_stall", {15'd0, wb.stall_out}, 16'h0);
      chk_eq("rst_count", wb.retire_count, 16'h0);

      // ALU write R3 = BEEF
      set_reads(3'd3, 3'd3, 3'd0);
      drive(1, 1, 3'd3, 16'hBEEF, 1, 0, 0, 16'h0);
      tick(1);
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
`ifdef WB_BYPASS_EN
      exp_beef = 16'hBEEF;
`else
      exp_beef = 16'h0000;
`endif
      #1;
      chk_eq("alu_n1_R3", wb.data_Rm, exp_beef);
      tick(1);
      #1;
      chk_eq("alu_R3", wb.data_Rm, 16'hBEEF);
      chk_eq("alu_count", wb.retire_count, 16'd1);

      // Load R5 with three idle memory cycles; update ignored while stalled
      drive(1, 1, 3'd5, 16'h0, 1, 1, 0, 16'h0);
      tick(1);
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      tick(1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 3'd6, 16'h6666, 1, 0, 0, 16'h0);
         #1;
         chk_eq("ld_stall", {15'd0, wb.stall_out}, 16'd1);
         chk_eq("ld_pending", {13'd0, wb.pending_Rd}, 16'd5);
         tick(1);
      end
      drive(0, 0, 3'd0, 16'h0, 0, 0, 1, 16'h1234);
      tick(1);
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      set_reads(3'd5, 3'd6, 3'd3);
      #1;
      chk_eq("ld_R5", wb.data_Rm, 16'h1234);
      chk_eq("ld_R6_ignored", wb.data_Rn, 16'h0000);
      chk_eq("ld_stall_done", {15'd0, wb.stall_out}, 16'd0);
      chk_eq("ld_count", wb.retire_count, 16'd2);
      tick(1);

      // Reset during LOAD_WAIT discards the load
      drive(1, 1, 3'd5, 16'h0, 1, 1, 0, 16'h0);
      tick(1);
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      tick(1);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      drive(0, 0, 3'd0, 16'h0, 0, 0, 1, 16'h5555);
      set_reads(3'd5, 3'd5, 3'd5);
      tick(1);
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      #1;
      chk_eq("rstld_R5", wb.data_Rm, 16'h0000);
      chk_eq("rstld_stall", {15'd0, wb.stall_out}, 16'd0);

      // Bubble and non-writing instruction
      set_reads(3'd2, 3'd4, 3'd2);
      drive(1, 0, 3'd2, 16'hAAAA, 1, 0, 0, 16'h0);
      tick(1);
      drive(1, 1, 3'd4, 16'hBBBB, 0, 0, 0, 16'h0);
      tick(1);
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      tick(1);
      tick(1);
      #1;
      chk_eq("bub_R2", wb.data_Rm, 16'h0000);
      chk_eq("nowr_R4", wb.data_Rn, 16'h0000);
      chk_eq("bub_count", wb.retire_count, 16'h0000);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) != 0);
         drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, 3'($urandom),
               16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, 16'($urandom));
         set_reads(3'($urandom), 3'($urandom), 3'($urandom));
         tick(1);
      end
      rst = 1'b1;

      // retire_count wrap
      rst = 1'b0;
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      tick(0);
      rst = 1'b1;
      n = 0;
      while (m_count != 16'hFFFF && n < 70000) begin
         drive(1, 1, 3'($urandom), 16'($urandom), 1, 0, 0, 16'h0);
         tick(0);
         n++;
      end
      drive(0, 0, 3'd0, 16'h0, 0, 0, 0, 16'h0);
      #1;
      chk_eq("wrap_ffff", wb.retire_count, 16'hFFFF);
      tick(1);
      #1;
      chk_eq("wrap_zero", wb.retire_count, 16'h0000);
      tick(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
